// File: rtl/pc_fetch_seq_if.sv
// Bus bundle between pc_fetch_seq (master) and its environment: PC-update
// stage, instruction memory, and the status/valid outputs toward the core.
interface pc_fetch_seq_if;
  logic [63:0] pc_update;
  logic        upd_valid;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [3:0]  imem_icode;
  logic        imem_err;
  logic [63:0] PC;
  logic        fetch_valid;
  logic        halted;
  logic [1:0]  stat;

  modport master (
    input  pc_update, upd_valid, imem_ack, imem_icode, imem_err,
    output imem_req, imem_addr, PC, fetch_valid, halted, stat
  );

  modport slave (
    output pc_update, upd_valid, imem_ack, imem_icode, imem_err,
    input  imem_req, imem_addr, PC, fetch_valid, halted, stat
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program-counter fetch sequencer: IDLE -> REQ -> WAIT loop with a terminal HALT.
// Optional retire counter enabled by defining PC_FETCH_RETIRE_CNT_EN.
module pc_fetch_seq #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_seq_if.master        bus
`ifdef PC_FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] ICODE_HALT    = 4'h0;
  localparam logic [3:0] ICODE_MAX_LEG = 4'hB;

  state_e      state_q, state_d;
  stat_e       stat_q, stat_d;
  logic [63:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        upd_accept;

  assign upd_accept = (state_q == S_WAIT) && bus.upd_valid;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    stat_d        = stat_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (bus.imem_ack) begin
          // Address error outranks any decode of the returned icode.
          if (bus.imem_err) begin
            state_d = S_HALT;
            stat_d  = STAT_ADR;
          end else if (bus.imem_icode == ICODE_HALT) begin
            state_d = S_HALT;
            stat_d  = STAT_HLT;
          end else if (bus.imem_icode > ICODE_MAX_LEG) begin
            state_d = S_HALT;
            stat_d  = STAT_INS;
          end else begin
            state_d       = S_WAIT;
            fetch_valid_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (upd_accept) begin
          pc_d    = bus.pc_update;
          state_d = S_REQ;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs simultaneously at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stat_q        <= STAT_AOK;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stat_q        <= stat_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Request is a pure decode of state, so it drops the edge after an ack or rst.
  assign bus.imem_req    = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.stat        = stat_q;

`ifdef PC_FETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Only accepted updates count; HALT never accepts, so the count freezes there.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (upd_accept) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= 32'd0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with RESET_PC=64'h100; inputs driven and
// outputs sampled on the falling clock edge.
module tb_pc_fetch_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  pc_fetch_seq_if bus ();

`ifdef PC_FETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  pc_fetch_seq #(.RESET_PC(64'h100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PC_FETCH_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.pc_update  = 64'h0;
    bus.upd_valid  = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_icode = 4'h0;
    bus.imem_err   = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst just released and the DUT in IDLE.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic ack(input logic [3:0] icode, input logic err);
    bus.imem_ack   = 1'b1;
    bus.imem_icode = icode;
    bus.imem_err   = err;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_icode = 4'h0;
    bus.imem_err   = 1'b0;
  endtask

  task automatic update(input logic [63:0] pc);
    bus.upd_valid = 1'b1;
    bus.pc_update = pc;
    step();
    bus.upd_valid = 1'b0;
    bus.pc_update = 64'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clear_inputs();
    step();
    step();

    check("rst_pc",     bus.PC,          64'h100);
    check("rst_stat",   bus.stat,        64'd0);
    check("rst_req",    bus.imem_req,    64'd0);
    check("rst_halted", bus.halted,      64'd0);
    check("rst_fv",     bus.fetch_valid, 64'd0);

    rst = 1'b0;
    check("idle_req", bus.imem_req, 64'd0);
    step();
    check("req_on",   bus.imem_req,  64'd1);
    check("req_addr", bus.imem_addr, 64'h100);

    // Memory stalls for three cycles; request and address must hold.
    step();
    step();
    step();
    check("req_held",      bus.imem_req,  64'd1);
    check("req_addr_held", bus.imem_addr, 64'h100);

    ack(4'h6, 1'b0);
    check("ack6_fv",  bus.fetch_valid, 64'd1);
    check("ack6_req", bus.imem_req,    64'd0);

    // An ack while in WAIT must not disturb anything.
    ack(4'h0, 1'b1);
    check("wait_ack_fv",   bus.fetch_valid, 64'd0);
    check("wait_ack_halt", bus.halted,      64'd0);
    check("wait_ack_stat", bus.stat,        64'd0);

    update(64'h10A);
    check("upd_req",  bus.imem_req,  64'd1);
    check("upd_addr", bus.imem_addr, 64'h10A);
    check("upd_pc",   bus.PC,        64'h10A);

    // upd_valid while in REQ is ignored.
    update(64'h999);
    check("req_upd_ignored", bus.PC,       64'h10A);
    check("req_upd_req",     bus.imem_req, 64'd1);

    // 4'hB is the largest legal icode.
    ack(4'hB, 1'b0);
    check("ackB_fv",   bus.fetch_valid, 64'd1);
    check("ackB_halt", bus.halted,      64'd0);
    check("ackB_stat", bus.stat,        64'd0);

    update(64'hFFFF_FFFF_FFFF_FFFF);
    check("upd_verbatim", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);

    ack(4'hC, 1'b0);
    check("ins_stat", bus.stat,        64'd3);
    check("ins_halt", bus.halted,      64'd1);
    check("ins_req",  bus.imem_req,    64'd0);
    check("ins_fv",   bus.fetch_valid, 64'd0);
    step();
    step();
    check("ins_req_stays", bus.imem_req, 64'd0);
    check("ins_stat_held", bus.stat,     64'd3);

    do_reset();
    check("rst2_pc",   bus.PC,     64'h100);
    check("rst2_stat", bus.stat,   64'd0);
    check("rst2_halt", bus.halted, 64'd0);
    step();
    check("rst2_req", bus.imem_req, 64'd1);

    ack(4'h0, 1'b0);
    check("hlt_stat", bus.stat,     64'd1);
    check("hlt_halt", bus.halted,   64'd1);
    check("hlt_req",  bus.imem_req, 64'd0);
    step();
    check("hlt_req_stays", bus.imem_req, 64'd0);

    do_reset();
    step();
    ack(4'h0, 1'b1);
    check("adr_stat", bus.stat,   64'd2);
    check("adr_halt", bus.halted, 64'd1);
    update(64'h555);
    check("adr_pc_frozen", bus.PC,   64'h100);
    check("adr_stat_held", bus.stat, 64'd2);

    // Reset and ack collide on the same edge: reset wins, no fetch_valid.
    do_reset();
    step();
    check("pre_col_req", bus.imem_req, 64'd1);
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_icode = 4'h6;
    step();
    check("col_req",  bus.imem_req,    64'd0);
    check("col_fv",   bus.fetch_valid, 64'd0);
    check("col_pc",   bus.PC,          64'h100);
    check("col_halt", bus.halted,      64'd0);
    rst = 1'b0;
    // Late ack lands in IDLE and must be ignored.
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_icode = 4'h0;
    check("col_late_fv",  bus.fetch_valid, 64'd0);
    check("col_late_req", bus.imem_req,    64'd1);

`ifdef PC_FETCH_RETIRE_CNT_EN
    ack(4'h1, 1'b0);
    check("cnt_after_rst", retire_cnt, 64'd0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    check("cnt_forced", retire_cnt, 64'hFFFF_FFFF);
    update(64'h200);
    check("cnt_wrap", retire_cnt, 64'd0);
    check("cnt_pc",   bus.PC,     64'h200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
